// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the register file's two write ports.
// W1 carries ALU results; W2 is shared by loads and APU results, which are buffered when they lose.
module regfile_wb_arbiter #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             alu_we_i,
    input  logic [ADDR_WIDTH-1:0]            alu_waddr_i,
    input  logic [DATA_WIDTH-1:0]            alu_wdata_i,
    input  logic                             lsu_we_i,
    input  logic [ADDR_WIDTH-1:0]            lsu_waddr_i,
    input  logic [DATA_WIDTH-1:0]            lsu_wdata_i,
    input  logic                             apu_valid_i,
    output logic                             apu_ready_o,
    input  logic [ADDR_WIDTH-1:0]            apu_waddr_i,
    input  logic [DATA_WIDTH-1:0]            apu_wdata_i,
    output logic                             we_a_o,
    output logic [ADDR_WIDTH-1:0]            waddr_a_o,
    output logic [DATA_WIDTH-1:0]            wdata_a_o,
    output logic                             we_b_o,
    output logic [ADDR_WIDTH-1:0]            waddr_b_o,
    output logic [DATA_WIDTH-1:0]            wdata_b_o,
    input  logic [ADDR_WIDTH-1:0]            chk_addr_i,
    output logic                             chk_hit_o,
    output logic [$clog2(FIFO_DEPTH):0]      apu_pending_o,
    output logic                             wb_conflict_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]      rd_ptr_reg;
    logic [PTR_W-1:0]      wr_ptr_reg;
    logic [CNT_W-1:0]      count_reg;
    logic [ADDR_WIDTH-1:0] addr_mem [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] data_mem [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] hold_addr_reg;
    logic [DATA_WIDTH-1:0] hold_data_reg;

    logic fifo_empty;
    logic fifo_full;
    logic lsu_sel;
    logic head_sel;
    logic bypass_sel;
    logic transfer;
    logic apu_nz;
    logic push;
    logic pop;
    logic [FIFO_DEPTH-1:0] entry_hit;

    assign fifo_empty = (count_reg == '0);
    assign fifo_full  = (count_reg == CNT_W'(FIFO_DEPTH));
    assign apu_nz     = (apu_waddr_i != '0);

    // Ready looks only at registered occupancy, so a full FIFO stays closed even while draining.
    assign apu_ready_o = !rst && !fifo_full;
    assign transfer    = apu_valid_i && apu_ready_o;

    assign lsu_sel    = !rst && lsu_we_i && (lsu_waddr_i != '0);
    assign head_sel   = !rst && !lsu_sel && !fifo_empty;
    assign bypass_sel = !rst && !lsu_sel && fifo_empty && transfer && apu_nz;
    assign push       = transfer && apu_nz && !bypass_sel;
    assign pop        = head_sel;

    assign we_a_o    = !rst && alu_we_i && (alu_waddr_i != '0);
    assign waddr_a_o = rst ? '0 : alu_waddr_i;
    assign wdata_a_o = rst ? '0 : alu_wdata_i;

    always_comb begin
        we_b_o    = 1'b0;
        waddr_b_o = hold_addr_reg;
        wdata_b_o = hold_data_reg;
        if (rst) begin
            waddr_b_o = '0;
            wdata_b_o = '0;
        end else if (lsu_sel) begin
            we_b_o    = 1'b1;
            waddr_b_o = lsu_waddr_i;
            wdata_b_o = lsu_wdata_i;
        end else if (head_sel) begin
            we_b_o    = 1'b1;
            waddr_b_o = addr_mem[rd_ptr_reg];
            wdata_b_o = data_mem[rd_ptr_reg];
        end else if (bypass_sel) begin
            we_b_o    = 1'b1;
            waddr_b_o = apu_waddr_i;
            wdata_b_o = apu_wdata_i;
        end
    end

    assign wb_conflict_o = we_a_o && we_b_o && (waddr_a_o == waddr_b_o);
    assign apu_pending_o = count_reg;

    // An entry is live when its distance from the read pointer is below the occupancy.
    generate
        for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_hit
            logic [PTR_W-1:0] offset;
            assign offset        = PTR_W'(gi) - rd_ptr_reg;
            assign entry_hit[gi] = ({1'b0, offset} < count_reg) && (addr_mem[gi] == chk_addr_i);
        end
    endgenerate

    assign chk_hit_o = !rst && (chk_addr_i != '0)
                       && ((|entry_hit) || (bypass_sel && (apu_waddr_i == chk_addr_i)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                addr_mem[i] <= '0;
                data_mem[i] <= '0;
            end
        end else if (push) begin
            addr_mem[wr_ptr_reg] <= apu_waddr_i;
            data_mem[wr_ptr_reg] <= apu_wdata_i;
        end
    end

    // Last W2 address/data are held so the port is quiet when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_addr_reg <= '0;
            hold_data_reg <= '0;
        end else if (we_b_o) begin
            hold_addr_reg <= waddr_b_o;
            hold_data_reg <= wdata_b_o;
        end
    end

    assert property (@(posedge clk) disable iff (rst) !(push && !pop && fifo_full));
    assert property (@(posedge clk) disable iff (rst) !(pop && fifo_empty));
    assert property (@(posedge clk) disable iff (rst) count_reg <= CNT_W'(FIFO_DEPTH));

endmodule
